// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU / effective address, iterative 64-bit mul/div/rem,
// registered results with a one-cycle execute_valid pulse, held stable across memory stalls.
module execute_stage #(
  parameter int XLEN          = 64,
  parameter int MULDIV_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            decode_valid,
  input  logic [XLEN-1:0] reg_decode_pc,
  input  logic [31:0]     reg_decode_ins,
  input  logic [XLEN-1:0] reg_decode_opa,
  input  logic [XLEN-1:0] reg_decode_opb,
  input  logic [XLEN-1:0] reg_decode_rd2,
  input  logic [4:0]      reg_decode_aluop,
  input  logic            reg_decode_word,
  input  logic [4:0]      reg_decode_rd,
  input  logic            reg_decode_reg_w,
  input  logic            reg_decode_mem_r,
  input  logic            reg_decode_mem_w,
  input  logic            reg_decode_sig,
  input  logic [2:0]      reg_decode_msize,
  input  logic            memory_stall,
  output logic            execute_valid,
  output logic [XLEN-1:0] reg_execute_data_out,
  output logic [XLEN-1:0] reg_execute_rd2,
  output logic [XLEN-1:0] reg_execute_pc,
  output logic [31:0]     reg_execute_ins,
  output logic [4:0]      reg_execute_rd,
  output logic [2:0]      reg_execute_msize,
  output logic            reg_execute_reg_w,
  output logic            reg_execute_mem_r,
  output logic            reg_execute_mem_w,
  output logic            reg_execute_sig,
  output logic            execute_stall,
  output logic [1:0]      o_dbg_state
);
  // Handshake: decode may pulse decode_valid only while execute_stall is low;
  // an instruction is taken exactly when decode_valid is high and execute_stall is low.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_HOLD = 2'd3} state_t;
  localparam int CW = $clog2(MULDIV_CYCLES + 1);

  state_t r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic            w_accept, w_is_md, w_last, w_load_single, w_load_md;
  logic [XLEN-1:0] w_alu, w_ext_a, w_ext_b, w_quo, w_rem, w_md_raw, w_md_res;
  logic [31:0]     w_a32, w_b32, w_r32;
  logic [XLEN-1:0] w_r64;
  logic [XLEN:0]   w_sh, w_diff;
  logic            w_sgn, w_neg_a, w_neg_b;

  // Latched multi-cycle operation context
  logic [4:0]      r_op;
  logic            r_word, r_neg_q, r_neg_r, r_bzero;
  logic [XLEN-1:0] r_acc, r_x, r_y, r_dividend;
  logic [XLEN-1:0] r_l_pc, r_l_rd2;
  logic [31:0]     r_l_ins;
  logic [4:0]      r_l_rd;
  logic [2:0]      r_l_msize;
  logic            r_l_reg_w, r_l_mem_r, r_l_mem_w, r_l_sig;

  assign w_is_md  = (reg_decode_aluop >= 5'd11) && (reg_decode_aluop <= 5'd15);
  assign w_accept = (r_state == S_IDLE) && decode_valid && !memory_stall && !r_valid;
  assign w_last   = (r_cnt == CW'(MULDIV_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_accept && w_is_md) w_next = (reg_decode_aluop == 5'd11) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (w_last) w_next = S_HOLD;
      S_HOLD:       if (!memory_stall) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load_single = w_accept && !w_is_md;
    w_load_md     = (r_state == S_HOLD) && !memory_stall;
    execute_stall = (r_state != S_IDLE) || memory_stall || r_valid;
    o_dbg_state   = r_state;
  end

  // Single-cycle ALU: word mode works on the low halves and sign-extends the 32-bit result
  always_comb begin
    w_a32 = reg_decode_opa[31:0];
    w_b32 = reg_decode_opb[31:0];
    case (reg_decode_aluop)
      5'd1:    begin w_r32 = w_a32 - w_b32; w_r64 = reg_decode_opa - reg_decode_opb; end
      5'd2:    begin w_r32 = w_a32 & w_b32; w_r64 = reg_decode_opa & reg_decode_opb; end
      5'd3:    begin w_r32 = w_a32 | w_b32; w_r64 = reg_decode_opa | reg_decode_opb; end
      5'd4:    begin w_r32 = w_a32 ^ w_b32; w_r64 = reg_decode_opa ^ reg_decode_opb; end
      5'd5:    begin w_r32 = w_a32 << w_b32[4:0]; w_r64 = reg_decode_opa << reg_decode_opb[5:0]; end
      5'd6:    begin w_r32 = w_a32 >> w_b32[4:0]; w_r64 = reg_decode_opa >> reg_decode_opb[5:0]; end
      5'd7:    begin
        w_r32 = $signed(w_a32) >>> w_b32[4:0];
        w_r64 = $signed(reg_decode_opa) >>> reg_decode_opb[5:0];
      end
      5'd8:    begin
        w_r32 = {31'd0, $signed(w_a32) < $signed(w_b32)};
        w_r64 = {{(XLEN-1){1'b0}}, $signed(reg_decode_opa) < $signed(reg_decode_opb)};
      end
      5'd9:    begin
        w_r32 = {31'd0, w_a32 < w_b32};
        w_r64 = {{(XLEN-1){1'b0}}, reg_decode_opa < reg_decode_opb};
      end
      5'd10:   begin w_r32 = w_b32; w_r64 = reg_decode_opb; end
      default: begin w_r32 = w_a32 + w_b32; w_r64 = reg_decode_opa + reg_decode_opb; end
    endcase
    w_alu = reg_decode_word ? {{(XLEN-32){w_r32[31]}}, w_r32} : w_r64;
  end

  // Operand preparation: signed word ops sign-extend, unsigned word ops zero-extend
  always_comb begin
    w_sgn   = (reg_decode_aluop == 5'd12) || (reg_decode_aluop == 5'd14) || (reg_decode_aluop == 5'd11);
    w_ext_a = reg_decode_opa;
    w_ext_b = reg_decode_opb;
    if (reg_decode_word) begin
      w_ext_a = {{(XLEN-32){w_sgn & reg_decode_opa[31]}}, reg_decode_opa[31:0]};
      w_ext_b = {{(XLEN-32){w_sgn & reg_decode_opb[31]}}, reg_decode_opb[31:0]};
    end
    w_neg_a = w_sgn && (reg_decode_aluop != 5'd11) && w_ext_a[XLEN-1];
    w_neg_b = w_sgn && (reg_decode_aluop != 5'd11) && w_ext_b[XLEN-1];
  end

  // Restoring divide step: r_acc is the partial remainder, r_y shifts dividend out / quotient in
  assign w_sh   = {r_acc, r_y[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_x};

  always_comb begin
    w_quo    = r_bzero ? {XLEN{1'b1}} : (r_neg_q ? -r_y : r_y);
    w_rem    = r_bzero ? r_dividend : (r_neg_r ? -r_acc : r_acc);
    w_md_raw = (r_op == 5'd11) ? r_acc :
               ((r_op == 5'd12) || (r_op == 5'd13)) ? w_quo : w_rem;
    w_md_res = r_word ? {{(XLEN-32){w_md_raw[31]}}, w_md_raw[31:0]} : w_md_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_op <= '0; r_word <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_bzero <= 1'b0;
      r_acc <= '0; r_x <= '0; r_y <= '0; r_dividend <= '0;
      r_l_pc <= '0; r_l_rd2 <= '0; r_l_ins <= '0; r_l_rd <= '0; r_l_msize <= '0;
      r_l_reg_w <= 1'b0; r_l_mem_r <= 1'b0; r_l_mem_w <= 1'b0; r_l_sig <= 1'b0;
    end else if (w_accept && w_is_md) begin
      r_cnt      <= '0;
      r_op       <= reg_decode_aluop;
      r_word     <= reg_decode_word;
      r_neg_q    <= w_neg_a ^ w_neg_b;
      r_neg_r    <= w_neg_a;
      r_bzero    <= (reg_decode_aluop != 5'd11) && (w_ext_b == '0);
      r_dividend <= w_ext_a;
      r_acc      <= '0;
      r_x        <= (reg_decode_aluop == 5'd11) ? w_ext_a : (w_neg_b ? -w_ext_b : w_ext_b);
      r_y        <= (reg_decode_aluop == 5'd11) ? w_ext_b : (w_neg_a ? -w_ext_a : w_ext_a);
      r_l_pc <= reg_decode_pc; r_l_rd2 <= reg_decode_rd2; r_l_ins <= reg_decode_ins;
      r_l_rd <= reg_decode_rd; r_l_msize <= reg_decode_msize;
      r_l_reg_w <= reg_decode_reg_w; r_l_mem_r <= reg_decode_mem_r;
      r_l_mem_w <= reg_decode_mem_w; r_l_sig <= reg_decode_sig;
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_y[0]) r_acc <= r_acc + r_x;
      r_x <= r_x << 1;
      r_y <= r_y >> 1;
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt + CW'(1);
      if (!w_diff[XLEN]) begin
        r_acc <= w_diff[XLEN-1:0];
        r_y   <= {r_y[XLEN-2:0], 1'b1};
      end else begin
        r_acc <= w_sh[XLEN-1:0];
        r_y   <= {r_y[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      reg_execute_data_out <= '0; reg_execute_rd2 <= '0; reg_execute_pc <= '0;
      reg_execute_ins <= '0; reg_execute_rd <= '0; reg_execute_msize <= 3'b011;
      reg_execute_reg_w <= 1'b0; reg_execute_mem_r <= 1'b0;
      reg_execute_mem_w <= 1'b0; reg_execute_sig <= 1'b0;
    end else begin
      r_valid <= w_load_single || w_load_md;
      if (w_load_single) begin
        reg_execute_data_out <= w_alu;
        reg_execute_rd2 <= reg_decode_rd2; reg_execute_pc <= reg_decode_pc;
        reg_execute_ins <= reg_decode_ins; reg_execute_rd <= reg_decode_rd;
        reg_execute_msize <= reg_decode_msize; reg_execute_reg_w <= reg_decode_reg_w;
        reg_execute_mem_r <= reg_decode_mem_r; reg_execute_mem_w <= reg_decode_mem_w;
        reg_execute_sig <= reg_decode_sig;
      end else if (w_load_md) begin
        reg_execute_data_out <= w_md_res;
        reg_execute_rd2 <= r_l_rd2; reg_execute_pc <= r_l_pc;
        reg_execute_ins <= r_l_ins; reg_execute_rd <= r_l_rd;
        reg_execute_msize <= r_l_msize; reg_execute_reg_w <= r_l_reg_w;
        reg_execute_mem_r <= r_l_mem_r; reg_execute_mem_w <= r_l_mem_w;
        reg_execute_sig <= r_l_sig;
      end
    end
  end

  assign execute_valid = r_valid;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, word mode, mul/div corner cases, stall hold and reset abort.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        decode_valid;
  logic [63:0] reg_decode_pc, reg_decode_opa, reg_decode_opb, reg_decode_rd2;
  logic [31:0] reg_decode_ins;
  logic [4:0]  reg_decode_aluop, reg_decode_rd;
  logic        reg_decode_word, reg_decode_reg_w, reg_decode_mem_r, reg_decode_mem_w, reg_decode_sig;
  logic [2:0]  reg_decode_msize;
  logic        memory_stall;
  logic        execute_valid, execute_stall;
  logic [63:0] reg_execute_data_out, reg_execute_rd2, reg_execute_pc;
  logic [31:0] reg_execute_ins;
  logic [4:0]  reg_execute_rd;
  logic [2:0]  reg_execute_msize;
  logic        reg_execute_reg_w, reg_execute_mem_r, reg_execute_mem_w, reg_execute_sig;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int failures = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .decode_valid(decode_valid),
    .reg_decode_pc(reg_decode_pc), .reg_decode_ins(reg_decode_ins),
    .reg_decode_opa(reg_decode_opa), .reg_decode_opb(reg_decode_opb),
    .reg_decode_rd2(reg_decode_rd2), .reg_decode_aluop(reg_decode_aluop),
    .reg_decode_word(reg_decode_word), .reg_decode_rd(reg_decode_rd),
    .reg_decode_reg_w(reg_decode_reg_w), .reg_decode_mem_r(reg_decode_mem_r),
    .reg_decode_mem_w(reg_decode_mem_w), .reg_decode_sig(reg_decode_sig),
    .reg_decode_msize(reg_decode_msize), .memory_stall(memory_stall),
    .execute_valid(execute_valid), .reg_execute_data_out(reg_execute_data_out),
    .reg_execute_rd2(reg_execute_rd2), .reg_execute_pc(reg_execute_pc),
    .reg_execute_ins(reg_execute_ins), .reg_execute_rd(reg_execute_rd),
    .reg_execute_msize(reg_execute_msize), .reg_execute_reg_w(reg_execute_reg_w),
    .reg_execute_mem_r(reg_execute_mem_r), .reg_execute_mem_w(reg_execute_mem_w),
    .reg_execute_sig(reg_execute_sig), .execute_stall(execute_stall),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Decode must never pulse while the stage is stalling
  always @(posedge clk) begin
    if (!rst && decode_valid) begin
      checks++;
      assert (execute_stall === 1'b0) else begin
        failures++;
        $error("FAIL decode_protocol observed_stall=%b expected_stall=0", execute_stall);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one decode pulse starting at the current falling edge; returns one cycle later
  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic word, input logic [2:0] msize, input logic mem_r);
    reg_decode_aluop = op; reg_decode_opa = a; reg_decode_opb = b; reg_decode_word = word;
    reg_decode_msize = msize; reg_decode_mem_r = mem_r; reg_decode_mem_w = 1'b0;
    reg_decode_reg_w = ~mem_r; reg_decode_sig = word; reg_decode_rd = 5'd10;
    reg_decode_pc = 64'h400; reg_decode_ins = 32'h0000_0013; reg_decode_rd2 = a ^ b;
    decode_valid = 1'b1;
    @(negedge clk);
    decode_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic stall_ok);
    lat = 0;
    stall_ok = 1'b1;
    while (!execute_valid && lat < 200) begin
      if (!execute_stall) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_single(input string tag, input logic [4:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic word, input logic [63:0] exp);
    issue(op, a, b, word, 3'b011, 1'b0);
    chk({tag, "_valid"}, {63'd0, execute_valid}, 64'd1);
    chk({tag, "_data"}, reg_execute_data_out, exp);
    @(negedge clk);
  endtask

  task automatic run_md(input string tag, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic word, input logic [63:0] exp);
    int lat;
    logic ok;
    issue(op, a, b, word, 3'b011, 1'b0);
    wait_valid(lat, ok);
    chk({tag, "_valid"}, {63'd0, execute_valid}, 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'd65);
    chk({tag, "_stall"}, {63'd0, ok}, 64'd1);
    chk({tag, "_data"}, reg_execute_data_out, exp);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [63:0] held;
    rst = 1'b1; decode_valid = 1'b0; memory_stall = 1'b0;
    reg_decode_pc = '0; reg_decode_ins = '0; reg_decode_opa = '0; reg_decode_opb = '0;
    reg_decode_rd2 = '0; reg_decode_aluop = '0; reg_decode_word = 1'b0; reg_decode_rd = '0;
    reg_decode_reg_w = 1'b0; reg_decode_mem_r = 1'b0; reg_decode_mem_w = 1'b0;
    reg_decode_sig = 1'b0; reg_decode_msize = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, execute_valid}, 64'd0);
    chk("rst_stall", {63'd0, execute_stall}, 64'd0);
    chk("rst_data", reg_execute_data_out, 64'd0);
    chk("rst_msize", {61'd0, reg_execute_msize}, 64'd3);
    chk("rst_state", {62'd0, o_dbg_state}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Load address with memory stall window
    issue(5'd0, 64'h1000, 64'h8, 1'b0, 3'b011, 1'b1);
    chk("ld_valid", {63'd0, execute_valid}, 64'd1);
    chk("ld_data", reg_execute_data_out, 64'h1008);
    chk("ld_stall", {63'd0, execute_stall}, 64'd1);
    chk("ld_mem_r", {63'd0, reg_execute_mem_r}, 64'd1);
    chk("ld_pc", reg_execute_pc, 64'h400);
    chk("ld_rd2", reg_execute_rd2, 64'h1008);
    memory_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reg_decode_opa = 64'hDEAD_0000 + 64'(i);
      chk("ld_hold_valid", {63'd0, execute_valid}, 64'd0);
      chk("ld_hold_stall", {63'd0, execute_stall}, 64'd1);
      chk("ld_hold_data", reg_execute_data_out, 64'h1008);
    end
    memory_stall = 1'b0;
    @(negedge clk);
    chk("ld_release_stall", {63'd0, execute_stall}, 64'd0);
    chk("ld_release_data", reg_execute_data_out, 64'h1008);

    // Single-cycle ALU vectors
    run_single("addw", 5'd0, 64'h7FFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_single("sra", 5'd7, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_single("sub", 5'd1, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_single("slt", 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd1);
    run_single("sltu", 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0);
    run_single("sllw", 5'd5, 64'd1, 64'd63, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_single("srl", 5'd6, 64'hF000_0000_0000_0000, 64'd4, 1'b0, 64'h0F00_0000_0000_0000);
    run_single("xor", 5'd4, 64'hFF00, 64'h0FF0, 1'b0, 64'hF0F0);
    run_single("passb", 5'd10, 64'h1234, 64'hABCD, 1'b0, 64'hABCD);

    // Multiply / divide
    run_md("mul", 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB);
    run_md("div0", 5'd12, 64'd7, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_md("rem0", 5'd14, 64'd7, 64'd0, 1'b0, 64'd7);
    run_md("divov", 5'd12, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000);
    run_md("remov", 5'd14, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0);
    run_md("divu", 5'd13, 64'd100, 64'd7, 1'b0, 64'd14);
    run_md("remu", 5'd15, 64'd100, 64'd7, 1'b0, 64'd2);
    run_md("divneg", 5'd12, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("remneg", 5'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_md("divwov", 5'd12, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000);

    // DIVU finishing under a memory stall that rose mid-iteration
    held = reg_execute_data_out;
    issue(5'd13, 64'd100, 64'd7, 1'b0, 3'b010, 1'b0);
    lat = 0;
    while (o_dbg_state != 2'd3 && lat < 200) begin
      if (lat == 30) memory_stall = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("hold_lat", 64'(lat), 64'd64);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_state", {62'd0, o_dbg_state}, 64'd3);
      chk("hold_novalid", {63'd0, execute_valid}, 64'd0);
    end
    chk("hold_data_kept", reg_execute_data_out, held);
    memory_stall = 1'b0;
    @(negedge clk);
    chk("hold_valid", {63'd0, execute_valid}, 64'd1);
    chk("hold_data", reg_execute_data_out, 64'd14);
    chk("hold_msize", {61'd0, reg_execute_msize}, 64'd2);
    chk("hold_idle", {62'd0, o_dbg_state}, 64'd0);
    @(negedge clk);

    // Reset in the middle of a divide
    issue(5'd12, 64'd100, 64'd7, 1'b0, 3'b001, 1'b0);
    repeat (30) @(negedge clk);
    chk("pre_rst_state", {62'd0, o_dbg_state}, 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", {62'd0, o_dbg_state}, 64'd0);
    chk("mid_rst_data", reg_execute_data_out, 64'd0);
    chk("mid_rst_msize", {61'd0, reg_execute_msize}, 64'd3);
    chk("mid_rst_reg_w", {63'd0, reg_execute_reg_w}, 64'd0);
    chk("mid_rst_valid", {63'd0, execute_valid}, 64'd0);
    chk("mid_rst_stall", {63'd0, execute_stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_single("post_rst_add", 5'd0, 64'd3, 64'd4, 1'b0, 64'd7);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (execute_valid) pulses++;
      @(negedge clk);
    end
    chk("aborted_div_no_valid", 64'(pulses), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline stage between decode and the memory stage.
- Computes ALU results, effective addresses and iterative 64-bit multiply/divide/remainder. Presents results on registered reg_execute_* outputs with a one-cycle execute_valid pulse.
- Holds the outputs stable while the memory stage is busy with a load/store.
- Back-pressures decode via execute_stall during multi-cycle ops and memory stalls.

Parameters:
- XLEN, 64, datapath width.
- MULDIV_CYCLES, 64, iterations of the shift-add multiplier and restoring divider (one result bit per cycle).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- decode_valid  in  1  one-cycle pulse: new instruction on reg_decode_* inputs
- reg_decode_pc  in  64  instruction PC
- reg_decode_ins  in  32  raw instruction
- reg_decode_opa  in  64  rs1 value (or PC for auipc/jal)
- reg_decode_opb  in  64  rs2 value or immediate
- reg_decode_rd2  in  64  rs2 value, store data
- reg_decode_aluop  in  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB, 11 MUL, 12 DIV, 13 DIVU, 14 REM, 15 REMU; others behave as ADD
- reg_decode_word  in  1  32-bit (*W) variant
- reg_decode_rd  in  5  destination register
- reg_decode_reg_w, reg_decode_mem_r, reg_decode_mem_w, reg_decode_sig  in  1 each  control flags passed through
- reg_decode_msize  in  3  access size, passed through
- memory_stall  in  1  memory stage busy with dbus access
- execute_valid  out  1  one-cycle result pulse to memory stage
- reg_execute_data_out  out  64  result or effective address
- reg_execute_rd2, reg_execute_pc  out  64  passed through
- reg_execute_ins  out  32  passed through
- reg_execute_rd  out  5  passed through
- reg_execute_msize  out  3  passed through
- reg_execute_reg_w, reg_execute_mem_r, reg_execute_mem_w, reg_execute_sig  out  1 each  passed through
- execute_stall  out  1  decode must hold its current instruction and must not pulse decode_valid

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0. All outputs 0 except reg_execute_msize=3'b011. execute_valid=0, execute_stall=0. An in-flight multi-cycle op is discarded.
- Accept condition: state IDLE && decode_valid && !memory_stall && !execute_valid.
  - The memory stage raises memory_stall the cycle after execute_valid, so no acceptance is allowed in the valid cycle.
  - A decode_valid outside the accept condition is a decode protocol violation. Behaviour is undefined and flagged by the bench assertion.
- execute_stall = (state != IDLE) || memory_stall || execute_valid.
- Single-cycle ops (aluop 0..10): on accept, all reg_execute_* load at the next edge and execute_valid=1 for exactly that one cycle. Latency 1.
- Loads/stores use ADD, so data_out = opa+opb (address).
- Shifts: amount opb[5:0], or opb[4:0] when word=1.
- SLT/SLTU return 0/1.
- Word mode: operate on opa[31:0]/opb[31:0]; result bits [31:0] sign-extended to 64.
- FSM states: IDLE, MUL, DIV, HOLD.
- MUL/DIV path:
  - On accept of aluop 11..15: latch all pass-through fields and operands, counter=0, go to MUL (11) or DIV (12..15).
  - Signed DIV/REM use operand magnitudes; signs are fixed at finish.
  - Word variants sign- or zero-extend the 32-bit operands first.
  - One iteration per cycle; after MULDIV_CYCLES iterations (counter == MULDIV_CYCLES-1), go to HOLD.
  - In HOLD, when !memory_stall, the outputs load, execute_valid pulses next cycle, and the state returns to IDLE. If memory_stall is high, stay in HOLD with the outputs untouched.
  - Nominal latency accept→valid = MULDIV_CYCLES+1 = 65 cycles.
  - MUL returns the low 64 bits of the product (word: low 32, sign-extended).
- Divide corner cases (RISC-V):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0. For word mode, MIN = 0x80000000 sign-extended.
- Output stability: while execute_valid=0, all reg_execute_* hold their last values. This covers the whole memory_stall window, so dreq stays constant.
- Overlap rule: memory_stall rising while a MUL/DIV is in progress does not pause the iterations. Only the HOLD→output step waits.

Test Plan:
- Reset assert mid-DIV at iteration 30 → outputs 0, msize=3, state IDLE. A decode_valid 2 cycles after release is accepted normally.
- ADD opa=0x1000, opb=0x8, mem_r=1, msize=3 → next cycle execute_valid=1, data_out=0x1008. execute_stall=1 during the valid cycle and the following memory_stall cycles; outputs constant until memory_stall falls.
- ADD word mode, opa=0x7FFFFFFF, opb=1 → data_out=0xFFFFFFFF80000000. SRA opa=0x8000000000000000, opb=63 → data_out=all ones.
- MUL opa=0xFFFFFFFFFFFFFFFF (-1), opb=5 → execute_valid exactly 65 cycles after accept, data_out=0xFFFFFFFFFFFFFFFB. execute_stall high throughout.
- DIV 7/0 → data_out=all ones. REM 7/0 → 7. DIV 0x8000000000000000/-1 → 0x8000000000000000. REM of the same → 0. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU completes while memory_stall=1 for 10 more cycles → state HOLD, no valid. Valid pulses the cycle after memory_stall falls, with the correct quotient.
